// File: rtl/sector_memory.sv
// sector_memory: simple-dual-port word memory with registered reads,
// write rejection and a hardware sector-erase engine (one word per cycle).
// Optional feature macro: SECTOR_LOCK_EN adds per-sector lock bits that
// block writes and erases. Without it, writes are rejected only during erase.
module sector_memory #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    SECTOR_BITS = 2,
    parameter logic [DATA_WIDTH-1:0] ERASE_VALUE = '1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    write_error,
    input  logic                    read_enable,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid,
    input  logic                    erase_req,
    input  logic [SECTOR_BITS-1:0]  erase_sector,
    output logic                    erase_busy,
    output logic                    erase_done,
    output logic                    erase_error,
    input  logic                    lock_set,
    input  logic                    lock_clear,
    input  logic [SECTOR_BITS-1:0]  lock_sector,
    output logic [2**SECTOR_BITS-1:0] lock_status
);

    localparam int OFFSET_BITS = ADDR_WIDTH - SECTOR_BITS;
    localparam int DEPTH       = 2**ADDR_WIDTH;
    localparam int SECTORS     = 2**SECTOR_BITS;
    localparam logic [OFFSET_BITS-1:0] PTR_LAST = '1;

    typedef enum logic {IDLE, ERASE} state_e;

    state_e                  state_q;
    logic [SECTOR_BITS-1:0]  sector_q;
    logic [OFFSET_BITS-1:0]  ptr_q;
    logic                    erase_busy_q;
    logic                    erase_done_q;
    logic                    erase_error_q;
    logic                    write_error_q;
    logic                    read_valid_q;
    logic [DATA_WIDTH-1:0]   data_out_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    write_locked;
    logic                    erase_locked;
    logic                    erase_accept;
    logic                    erase_reject;
    logic                    write_accept;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

`ifdef SECTOR_LOCK_EN
    logic [SECTORS-1:0]      lock_q;
    logic [SECTORS-1:0]      lock_d;
    logic [SECTOR_BITS-1:0]  write_sector;

    assign write_sector = write_address[ADDR_WIDTH-1 -: SECTOR_BITS];

    // Next lock bits: clear first, then set, so a simultaneous set wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lock_d = lock_q;
        if (lock_clear) lock_d[lock_sector] = 1'b0;
        if (lock_set)   lock_d[lock_sector] = 1'b1;
    end

    // Lock register; cleared by reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) lock_q <= '0;
        else       lock_q <= lock_d;
    end

    assign write_locked = lock_q[write_sector];
    assign erase_locked = lock_q[erase_sector];
    assign lock_status  = lock_q;
`else
    logic unused_lock_inputs;
    assign unused_lock_inputs = ^{lock_set, lock_clear, lock_sector};
    assign write_locked = 1'b0;
    assign erase_locked = 1'b0;
    assign lock_status  = '0;
`endif

    // Erase has priority over the host write port in the accepting cycle.
    assign erase_accept = (state_q == IDLE) && erase_req && !erase_locked;
    assign erase_reject = (state_q == IDLE) && erase_req &&  erase_locked;
    assign write_accept = write_enable && (state_q == IDLE) && !erase_accept && !write_locked;

    // Erase FSM: latches the sector, sweeps the pointer, pulses done/error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            sector_q      <= '0;
            ptr_q         <= '0;
            erase_busy_q  <= 1'b0;
            erase_done_q  <= 1'b0;
            erase_error_q <= 1'b0;
        end else begin
            erase_done_q  <= 1'b0;
            erase_error_q <= erase_reject;
            case (state_q)
                IDLE: begin
                    if (erase_accept) begin
                        state_q      <= ERASE;
                        sector_q     <= erase_sector;
                        ptr_q        <= '0;
                        erase_busy_q <= 1'b1;
                    end
                end
                ERASE: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_q      <= IDLE;
                        erase_busy_q <= 1'b0;
                        erase_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Single array write port, owned by the erase engine while erasing.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_address;
        mem_wdata = data_in;
        if (state_q == ERASE) begin
            mem_we    = 1'b1;
            mem_waddr = {sector_q, ptr_q};
            mem_wdata = ERASE_VALUE;
        end else if (write_accept) begin
            mem_we = 1'b1;
        end
        if (reset) mem_we = 1'b0;
    end

    // Array storage.
    always_ff @(posedge clock) begin
        // NOTE: the array is deliberately not reset; reset leaves contents intact.
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Registered read port (read-first) and write-rejection flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_q    <= '0;
            read_valid_q  <= 1'b0;
            write_error_q <= 1'b0;
        end else begin
            read_valid_q  <= read_enable;
            write_error_q <= write_enable && !write_accept;
            if (read_enable) data_out_q <= mem[read_address];
        end
    end

    assign data_out    = data_out_q;
    assign read_valid  = read_valid_q;
    assign write_error = write_error_q;
    assign erase_busy  = erase_busy_q;
    assign erase_done  = erase_done_q;
    assign erase_error = erase_error_q;

endmodule

// File: tb/tb_sector_memory.sv
// tb_sector_memory: randomized and directed checks of sector_memory against
// an array-based reference model. Honours SECTOR_LOCK_EN like the design.
module tb_sector_memory;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int SB  = 2;
    localparam int WPS = 64;
    localparam logic [DW-1:0] ERASED = 32'hFFFF_FFFF;

    logic          clock = 1'b0;
    logic          reset;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [DW-1:0] data_in;
    logic          write_error;
    logic          read_enable;
    logic [AW-1:0] read_address;
    logic [DW-1:0] data_out;
    logic          read_valid;
    logic          erase_req;
    logic [SB-1:0] erase_sector;
    logic          erase_busy;
    logic          erase_done;
    logic          erase_error;
    logic          lock_set;
    logic          lock_clear;
    logic [SB-1:0] lock_sector;
    logic [2**SB-1:0] lock_status;

    sector_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SECTOR_BITS(SB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_address(write_address),
        .data_in      (data_in),
        .write_error  (write_error),
        .read_enable  (read_enable),
        .read_address (read_address),
        .data_out     (data_out),
        .read_valid   (read_valid),
        .erase_req    (erase_req),
        .erase_sector (erase_sector),
        .erase_busy   (erase_busy),
        .erase_done   (erase_done),
        .erase_error  (erase_error),
        .lock_set     (lock_set),
        .lock_clear   (lock_clear),
        .lock_sector  (lock_sector),
        .lock_status  (lock_status)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: plain word array holding what every address should contain.
    logic [DW-1:0] model [2**AW];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        erase_req    = 1'b0;
        lock_set     = 1'b0;
        lock_clear   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"},    data_out,    '0);
        check({tag, "_read_valid"},  read_valid,  0);
        check({tag, "_write_error"}, write_error, 0);
        check({tag, "_erase_busy"},  erase_busy,  0);
        check({tag, "_erase_done"},  erase_done,  0);
        check({tag, "_erase_error"}, erase_error, 0);
        check({tag, "_lock_status"}, lock_status, 0);
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp_err);
        write_enable  = 1'b1;
        write_address = a;
        data_in       = d;
        step();
        write_enable  = 1'b0;
        check($sformatf("write_error[%02h]", a), write_error, exp_err);
        if (!exp_err) model[a] = d;
    endtask

    task automatic read_word(input logic [AW-1:0] a);
        read_enable  = 1'b1;
        read_address = a;
        step();
        read_enable  = 1'b0;
        check($sformatf("read_valid[%02h]", a), read_valid, 1);
        check($sformatf("read_data[%02h]", a), data_out, model[a]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests so far %0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            cyc;
        bit            flag;
        logic [DW-1:0] last_rd;
        logic [DW-1:0] exp_rd;

        reset         = 1'b1;
        write_address = '0;
        data_in       = '0;
        read_address  = '0;
        erase_sector  = '0;
        lock_sector   = '0;
        idle_inputs();
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;

        // Basic write then read.
        write_word(8'h05, 32'hDEAD_BEEF, 0);
        read_word(8'h05);
        check("read_deadbeef", data_out, 32'hDEAD_BEEF);

        // Same-cycle write and read to one address returns the old word.
        write_enable  = 1'b1; write_address = 8'h05; data_in = 32'h1234_5678;
        read_enable   = 1'b1; read_address  = 8'h05;
        step();
        idle_inputs();
        check("rw_same_valid", read_valid, 1);
        check("rw_same_old",   data_out, 32'hDEAD_BEEF);
        check("rw_same_werr",  write_error, 0);
        model[5] = 32'h1234_5678;
        read_word(8'h05);
        step();
        check("read_valid_pulse", read_valid, 0);
        check("data_out_held", data_out, 32'h1234_5678);

        // Fill the whole array with random words.
        for (int a = 0; a < 2**AW; a++) write_word(AW'(a), $urandom, 0);

        // Random traffic while idle.
        last_rd = data_out;
        for (int i = 0; i < 300; i++) begin
            write_enable  = 1'($urandom_range(0, 1));
            write_address = AW'($urandom);
            data_in       = $urandom;
            read_enable   = 1'($urandom_range(0, 1));
            read_address  = AW'($urandom);
            exp_rd        = model[read_address];
            step();
            if (read_enable) last_rd = exp_rd;
            check("rnd_read_valid", read_valid, read_enable);
            check("rnd_data_out", data_out, last_rd);
            check("rnd_write_error", write_error, 0);
            if (write_enable) model[write_address] = data_in;
        end
        idle_inputs();

        // Erase sector 1; a write in the accepting cycle is rejected.
        erase_req     = 1'b1; erase_sector = 2'd1;
        write_enable  = 1'b1; write_address = 8'h10; data_in = $urandom;
        step();
        idle_inputs();
        check("accept_write_error", write_error, 1);
        check("busy_after_accept", erase_busy, 1);
        cyc  = 0;
        flag = 0;
        while (erase_busy && cyc < 200) begin
            cyc++;
            if (erase_done) flag = 1;
            if (cyc == 3) begin
                read_enable = 1'b1; read_address = 8'h40;
            end
            if (cyc == 5) begin
                read_enable  = 1'b1; read_address = 8'h7F;
                write_enable = 1'b1; write_address = 8'h20; data_in = $urandom;
                erase_req    = 1'b1; erase_sector = 2'd3;
            end
            step();
            idle_inputs();
            if (cyc == 3) check("erase_partial_40", data_out, ERASED);
            if (cyc == 5) begin
                check("erase_partial_7f", data_out, model[8'h7F]);
                check("erase_write_rejected", write_error, 1);
                check("erase_req_ignored_err", erase_error, 0);
            end
        end
        check("erase_busy_cycles", cyc, WPS);
        check("erase_done_pulse", erase_done, 1);
        check("erase_done_early", flag, 0);
        step();
        check("erase_done_once", erase_done, 0);
        check("erase_req_ignored_busy", erase_busy, 0);
        for (int a = 8'h40; a <= 8'h7F; a++) model[a] = ERASED;
        for (int a = 0; a < 2**AW; a++) read_word(AW'(a));

`ifdef SECTOR_LOCK_EN
        lock_set = 1'b1; lock_sector = 2'd2;
        step();
        idle_inputs();
        check("lock_status_s2", lock_status, 4'b0100);
        write_word(8'h80, $urandom, 1);
        read_word(8'h80);
        erase_req = 1'b1; erase_sector = 2'd2;
        step();
        idle_inputs();
        check("locked_erase_error", erase_error, 1);
        check("locked_erase_busy", erase_busy, 0);
        step();
        check("erase_error_pulse", erase_error, 0);
        check("locked_erase_still_idle", erase_busy, 0);
        lock_set = 1'b1; lock_clear = 1'b1; lock_sector = 2'd2;
        step();
        idle_inputs();
        check("set_clear_s2", lock_status, 4'b0100);
        lock_set = 1'b1; lock_clear = 1'b1; lock_sector = 2'd0;
        step();
        idle_inputs();
        check("set_clear_s0", lock_status, 4'b0101);
        lock_clear = 1'b1; lock_sector = 2'd0;
        step();
        idle_inputs();
        check("clear_s0", lock_status, 4'b0100);
        write_word(8'hC0, $urandom, 0);
        read_word(8'hC0);
`else
        lock_set = 1'b1; lock_sector = 2'd2;
        step();
        idle_inputs();
        check("lock_ignored_status", lock_status, 0);
        write_word(8'h80, $urandom, 0);
        read_word(8'h80);
`endif

        // Reset ten cycles into an erase of sector 1.
        for (int a = 8'h40; a <= 8'h7F; a++) write_word(AW'(a), $urandom, 0);
        read_word(8'h4A);
        erase_req = 1'b1; erase_sector = 2'd1;
        step();
        idle_inputs();
        repeat (10) step();
        reset = 1'b1;
        step();
        check_all_zero("mid_erase_reset");
        reset = 1'b0;
        for (int a = 8'h40; a <= 8'h49; a++) model[a] = ERASED;
        flag = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (erase_done || erase_busy) flag = 1;
        end
        check("no_done_after_abort", flag, 0);
        for (int a = 0; a < 2**AW; a++) read_word(AW'(a));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
